arbitro_registro: RTL and testbench

ARBITRO_REGISTRO -- requirements
Module: arbitro_registro

---
 rtl/arbitro_registro_pkg.sv | 27 ++
 rtl/rr_selector.sv | 46 ++++
 rtl/arbitro_registro.sv | 139 +++++++++++++
 tb/tb_arbitro_registro.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/arbitro_registro_pkg.sv
// ============================================================================
// arbitro_registro_pkg : shared defaults, state encoding and helpers
// Rev 1.0
// ============================================================================
`default_nettype none

package arbitro_registro_pkg;

    localparam int WIDTH_DEF = 12;
    localparam int N_REQ_DEF = 4;
    localparam int HOLD_DEF  = 2;
    localparam int CNT_W     = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_HOLD = 2'd2,
        ST_ACK  = 2'd3
    } state_t;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/rr_selector.sv
// ============================================================================
// rr_selector : combinational round-robin picker, first request at/after ptr
// Rev 1.0
// ============================================================================
`default_nettype none

module rr_selector
    import arbitro_registro_pkg::*;
#(
    parameter int N_REQ = N_REQ_DEF,
    parameter int IDX_W = idx_w(N_REQ_DEF)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N_REQ-1:0] winner,
    output logic [IDX_W-1:0] index,
    output logic             valid
);

    logic [IDX_W:0]   w_sum;
    logic [IDX_W-1:0] w_pos;

    always_comb begin
        winner = '0;
        index  = '0;
        valid  = 1'b0;
        w_sum  = '0;
        w_pos  = '0;
        for (int k = 0; k < N_REQ; k++) begin
            // Offset from ptr, folded back into 0..N_REQ-1
            w_sum = {1'b0, ptr} + (IDX_W+1)'(k);
            if (w_sum >= (IDX_W+1)'(N_REQ)) begin
                w_sum = w_sum - (IDX_W+1)'(N_REQ);
            end
            w_pos = w_sum[IDX_W-1:0];
            if (!valid && req[w_pos]) begin
                winner[w_pos] = 1'b1;
                index         = w_pos;
                valid         = 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/arbitro_registro.sv
// ============================================================================
// arbitro_registro : round-robin arbiter loading one requester code into a
//                    shared register with LOAD/HOLD/ACK handshake
// Rev 1.0
// ============================================================================
`default_nettype none

module arbitro_registro
    import arbitro_registro_pkg::*;
#(
    parameter int WIDTH       = WIDTH_DEF,
    parameter int N_REQ       = N_REQ_DEF,
    parameter int HOLD_CYCLES = HOLD_DEF
) (
    input  logic                   clk,
    input  logic                   clr,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ*WIDTH-1:0] datos,
    output logic [WIDTH-1:0]       L,
    output logic                   en,
    output logic [N_REQ-1:0]       gnt,
    output logic [N_REQ-1:0]       ack,
    output logic                   busy,
    output logic [CNT_W-1:0]       cnt_cargas
);

    localparam int IDX_W = idx_w(N_REQ);
    localparam int HC_W  = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

    state_t           r_state, w_state;
    logic [IDX_W-1:0] r_ptr, w_ptr;
    logic [IDX_W-1:0] r_win, w_win;
    logic [HC_W-1:0]  r_hold, w_hold;

    logic [WIDTH-1:0] w_l;
    logic             w_en;
    logic [N_REQ-1:0] w_gnt;
    logic [N_REQ-1:0] w_ack;
    logic             w_busy;
    logic [CNT_W-1:0] w_cnt;

    logic [N_REQ-1:0] w_sel_onehot;
    logic [IDX_W-1:0] w_sel_idx;
    logic             w_sel_valid;
    logic [WIDTH-1:0] w_sel_code;

    rr_selector #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_sel (
        .req    (req),
        .ptr    (r_ptr),
        .winner (w_sel_onehot),
        .index  (w_sel_idx),
        .valid  (w_sel_valid)
    );

    always_comb begin
        w_sel_code = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (w_sel_onehot[i]) begin
                w_sel_code = datos[i*WIDTH +: WIDTH];
            end
        end
    end

    always_comb begin
        w_state = r_state;
        w_ptr   = r_ptr;
        w_win   = r_win;
        w_hold  = r_hold;
        w_l     = L;
        w_en    = 1'b0;
        w_gnt   = gnt;
        w_ack   = '0;
        w_cnt   = cnt_cargas;
        case (r_state)
            ST_IDLE: begin
                if (w_sel_valid) begin
                    w_l     = w_sel_code;
                    w_gnt   = w_sel_onehot;
                    w_win   = w_sel_idx;
                    w_en    = 1'b1;
                    w_state = ST_LOAD;
                end
            end
            ST_LOAD: begin
                w_hold  = '0;
                w_state = ST_HOLD;
            end
            ST_HOLD: begin
                if (r_hold == HC_W'(HOLD_CYCLES-1)) begin
                    w_state = ST_ACK;
                    w_ack   = gnt;
                    w_cnt   = cnt_cargas + CNT_W'(1);
                    // Advance past the winner so other pending requesters go first
                    w_ptr   = (r_win == IDX_W'(N_REQ-1)) ? '0 : r_win + IDX_W'(1);
                end else begin
                    w_hold  = r_hold + HC_W'(1);
                end
            end
            ST_ACK: begin
                w_gnt   = '0;
                w_state = ST_IDLE;
            end
            default: w_state = ST_IDLE;
        endcase
        w_busy = (w_state != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            r_state    <= ST_IDLE;
            r_ptr      <= '0;
            r_win      <= '0;
            r_hold     <= '0;
            L          <= '0;
            en         <= 1'b0;
            gnt        <= '0;
            ack        <= '0;
            busy       <= 1'b0;
            cnt_cargas <= '0;
        end else begin
            r_state    <= w_state;
            r_ptr      <= w_ptr;
            r_win      <= w_win;
            r_hold     <= w_hold;
            L          <= w_l;
            en         <= w_en;
            gnt        <= w_gnt;
            ack        <= w_ack;
            busy       <= w_busy;
            cnt_cargas <= w_cnt;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_arbitro_registro.sv
// ============================================================================
// tb_arbitro_registro : timeline model compare plus directed literal checks
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_arbitro_registro;

    localparam int W = 12;
    localparam int N = 4;
    localparam int H = 2;

    logic           clk = 1'b0;
    logic           clr = 1'b1;
    logic [N-1:0]   req = '0;
    logic [N*W-1:0] datos = '0;
    logic [W-1:0]   L;
    logic           en;
    logic [N-1:0]   gnt;
    logic [N-1:0]   ack;
    logic           busy;
    logic [7:0]     cnt_cargas;

    arbitro_registro #(.WIDTH(W), .N_REQ(N), .HOLD_CYCLES(H)) dut (
        .clk        (clk),
        .clr        (clr),
        .req        (req),
        .datos      (datos),
        .L          (L),
        .en         (en),
        .gnt        (gnt),
        .ack        (ack),
        .busy       (busy),
        .cnt_cargas (cnt_cargas)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    bit chk_on = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction timeline model: a grant at edge s gives en after s, ack after
    // s+1+H, idle outputs after s+2+H, next arbitration at edge s+3+H.
    int           cyc = 0;
    int           m_start = 0;
    int           m_win = 0;
    int           m_ptr = 0;
    int           m_d;
    int           m_p;
    bit           m_act = 1'b0;
    bit           m_found;
    logic [W-1:0] e_l = '0;
    logic [7:0]   e_cnt = '0;
    logic         e_en = 1'b0;
    logic         e_busy = 1'b0;
    logic [N-1:0] e_gnt = '0;
    logic [N-1:0] e_ack = '0;

    always @(posedge clk) begin
        cyc++;
        if (clr) begin
            m_act = 1'b0;
            m_ptr = 0;
            e_l   = '0;
            e_cnt = '0;
        end else begin
            if (m_act && (cyc - m_start) > 2 + H) m_act = 1'b0;
            if (!m_act && req != '0) begin
                m_found = 1'b0;
                for (int k = 0; k < N; k++) begin
                    m_p = (m_ptr + k) % N;
                    if (!m_found && req[m_p]) begin
                        m_win   = m_p;
                        m_found = 1'b1;
                    end
                end
                m_act   = 1'b1;
                m_start = cyc;
                e_l     = datos[m_win*W +: W];
            end
        end
        m_d    = cyc - m_start;
        e_en   = m_act && (m_d == 0);
        e_gnt  = (m_act && m_d <= 1 + H) ? N'(1 << m_win) : '0;
        e_ack  = (m_act && m_d == 1 + H) ? N'(1 << m_win) : '0;
        e_busy = m_act && (m_d <= 1 + H);
        if (m_act && m_d == 1 + H) begin
            e_cnt = e_cnt + 8'd1;
            m_ptr = (m_win + 1) % N;
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            chk("L", 32'(L), 32'(e_l));
            chk("en", 32'(en), 32'(e_en));
            chk("gnt", 32'(gnt), 32'(e_gnt));
            chk("ack", 32'(ack), 32'(e_ack));
            chk("busy", 32'(busy), 32'(e_busy));
            chk("cnt_cargas", 32'(cnt_cargas), 32'(e_cnt));
        end
    end

    task automatic wait_en(output logic [W-1:0] code);
        bit ok = 1'b0;
        code = '0;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            if (en === 1'b1) begin
                code = L;
                ok   = 1'b1;
            end
        end
        if (!ok) begin
            total++;
            bad++;
            $display("FAIL wait_en: got no en within 20 cycles, want en");
        end
    endtask

    task automatic wait_ack(output int idx);
        bit ok = 1'b0;
        idx = -1;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            if (ack !== '0) begin
                for (int b = 0; b < N; b++) if (ack[b]) idx = b;
                ok = 1'b1;
            end
        end
        if (!ok) begin
            total++;
            bad++;
            $display("FAIL wait_ack: got no ack within 20 cycles, want ack");
        end
    endtask

    task automatic clr_pulse();
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
    endtask

    logic [W-1:0] exp_rr_l [5] = '{12'h0C4, 12'hD11, 12'h795, 12'h123, 12'h0C4};
    int           exp_rr_a [5] = '{0, 1, 2, 3, 0};

    initial begin
        logic [W-1:0] code;
        int           idx;
        int           n;

        // Reset held for two cycles with every requester active
        clr   = 1'b1;
        req   = 4'b1111;
        datos = {12'h123, 12'h795, 12'hD11, 12'h0C4};
        @(negedge clk);
        chk_on = 1'b1;
        chk("rst_en1", 32'(en), 32'd0);
        @(negedge clk);
        chk("rst_en2", 32'(en), 32'd0);
        chk("rst_L", 32'(L), 32'd0);
        chk("rst_gnt", 32'(gnt), 32'd0);
        chk("rst_ack", 32'(ack), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_cnt", 32'(cnt_cargas), 32'd0);
        req = '0;
        clr = 1'b0;

        // Single request, dropped right after the load strobe
        req = 4'b0001;
        wait_en(code);
        chk("single_L", 32'(code), 32'h0C4);
        req = '0;
        repeat (3) @(negedge clk);
        chk("single_ack", 32'(ack), 32'b0001);
        chk("single_cnt", 32'(cnt_cargas), 32'd1);

        // Round-robin with all four requests held
        clr_pulse();
        req = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            wait_en(code);
            chk("rr_L", 32'(code), 32'(exp_rr_l[i]));
            wait_ack(idx);
            chk("rr_ack_idx", 32'(idx), 32'(exp_rr_a[i]));
            if (i == 4) req = '0;
        end

        // Source data changes during HOLD must not reach L
        clr_pulse();
        req = 4'b0100;
        wait_en(code);
        chk("dchg_L_load", 32'(code), 32'h795);
        req = '0;
        @(negedge clk);
        datos[2*W +: W] = 12'hFFF;
        @(negedge clk);
        chk("dchg_L_hold", 32'(L), 32'h795);
        @(negedge clk);
        chk("dchg_L_ack", 32'(L), 32'h795);
        chk("dchg_ack", 32'(ack), 32'b0100);
        @(negedge clk);
        chk("dchg_L_after", 32'(L), 32'h795);
        datos[2*W +: W] = 12'h795;

        // Reset during HOLD aborts the transaction
        clr_pulse();
        req = 4'b0010;
        wait_en(code);
        chk("abort_L_load", 32'(code), 32'hD11);
        req = '0;
        @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        chk("abort_L", 32'(L), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_gnt", 32'(gnt), 32'd0);
        chk("abort_cnt", 32'(cnt_cargas), 32'd0);
        repeat (6) begin
            @(negedge clk);
            chk("abort_no_ack", 32'(ack), 32'd0);
        end

        // 256 loads wrap the counter back to zero
        clr_pulse();
        req = 4'b0001;
        n   = 0;
        for (int c = 0; c < 256 * 8 && n < 256; c++) begin
            @(negedge clk);
            if (ack !== '0) begin
                n++;
                if (n == 255) chk("wrap_cnt255", 32'(cnt_cargas), 32'd255);
                if (n == 256) begin
                    chk("wrap_cnt0", 32'(cnt_cargas), 32'd0);
                    req = '0;
                end
            end
        end
        chk("wrap_acks", 32'(n), 32'd256);

        repeat (4) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
